// File: rtl/cvxif_copro_exec_stage.sv
// CV-X-IF example coprocessor execute/result stage.
// Single-cycle ALU ops, multi-cycle MUL, in-order result FIFO.
module cvxif_copro_exec_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NrRgprPorts = 2,
    parameter int unsigned HartIdWidth = 1,
    parameter int unsigned IdWidth     = 3,
    parameter int unsigned FifoDepth   = 4,
    parameter int unsigned MulLatency  = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          op_valid_i,
    output logic                          op_ready_o,
    input  logic [3:0]                    opcode_i,
    input  logic [NrRgprPorts*XLEN-1:0]   registers_i,
    input  logic [HartIdWidth-1:0]        hartid_i,
    input  logic [IdWidth-1:0]            id_i,
    input  logic [4:0]                    rd_i,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic [HartIdWidth-1:0]        result_hartid_o,
    output logic [IdWidth-1:0]            result_id_o,
    output logic [XLEN-1:0]               result_data_o,
    output logic [4:0]                    result_rd_o,
    output logic                          result_we_o,
    output logic                          busy_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = (MulLatency > 1) ? $clog2(MulLatency) : 1;

    typedef enum logic {IDLE, MUL} state_t;

    typedef struct packed {
        logic [HartIdWidth-1:0] hartid;
        logic [IdWidth-1:0]     id;
        logic [XLEN-1:0]        data;
        logic [4:0]             rd;
        logic                   we;
    } entry_t;

    state_t                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]        mul_a_q, mul_a_d;
    logic [XLEN-1:0]        mul_b_q, mul_b_d;
    logic [HartIdWidth-1:0] mul_hartid_q, mul_hartid_d;
    logic [IdWidth-1:0]     mul_id_q, mul_id_d;
    logic [4:0]             mul_rd_q, mul_rd_d;
    logic                   mul_we_q, mul_we_d;
    entry_t                 fifo_q [FifoDepth];
    entry_t                 fifo_d [FifoDepth];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]          count_q, count_d;

    logic [XLEN-1:0] rs1, rs2, rs3;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] mul_prod;
    logic            we_in;
    logic            accept;
    logic            push, pop;
    entry_t          push_entry;
    entry_t          head;

    assign rs1 = registers_i[XLEN-1:0];
    assign rs2 = registers_i[2*XLEN-1:XLEN];

    if (NrRgprPorts > 2) begin : g_rs3
        assign rs3 = registers_i[3*XLEN-1:2*XLEN];
    end else begin : g_no_rs3
        assign rs3 = '0;
    end

    assign mul_prod = mul_a_q * mul_b_q;

    // Single-cycle ALU result and write-enable for the incoming op
    always_comb begin
        alu_res = '0;
        unique case (opcode_i)
            4'd1:    alu_res = rs1 + rs2;
            4'd2:    alu_res = rs1 - rs2;
            4'd4:    alu_res = rs1 + rs2 + rs3;
            default: alu_res = '0;
        endcase
        we_in = (opcode_i >= 4'd1) && (opcode_i <= 4'd4) && (rd_i != 5'd0);
    end

    assign op_ready_o = (state_q == IDLE) && (count_q < (PtrW+1)'(FifoDepth));
    assign accept     = op_valid_i && op_ready_o;
    assign pop        = (count_q != '0) && result_ready_i;

    // FSM next state, MUL operand capture and FIFO bookkeeping
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_hartid_d = mul_hartid_q;
        mul_id_d     = mul_id_q;
        mul_rd_d     = mul_rd_q;
        mul_we_d     = mul_we_q;
        push         = 1'b0;
        push_entry   = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (opcode_i == 4'd3) begin
                        state_d      = MUL;
                        cnt_d        = CntW'(MulLatency - 1);
                        mul_a_d      = rs1;
                        mul_b_d      = rs2;
                        mul_hartid_d = hartid_i;
                        mul_id_d     = id_i;
                        mul_rd_d     = rd_i;
                        mul_we_d     = we_in;
                    end else begin
                        push       = 1'b1;
                        push_entry = '{hartid: hartid_i, id: id_i,
                                       data: alu_res, rd: rd_i, we: we_in};
                    end
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    push       = 1'b1;
                    push_entry = '{hartid: mul_hartid_q, id: mul_id_q,
                                   data: mul_prod, rd: mul_rd_q, we: mul_we_q};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_hartid_q <= '0;
            mul_id_q     <= '0;
            mul_rd_q     <= '0;
            mul_we_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < int'(FifoDepth); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_hartid_q <= mul_hartid_d;
            mul_id_q     <= mul_id_d;
            mul_rd_q     <= mul_rd_d;
            mul_we_q     <= mul_we_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fifo_q       <= fifo_d;
        end
    end

    assign head = fifo_q[rd_ptr_q];

    assign result_valid_o  = (count_q != '0);
    assign result_hartid_o = result_valid_o ? head.hartid : '0;
    assign result_id_o     = result_valid_o ? head.id     : '0;
    assign result_data_o   = result_valid_o ? head.data   : '0;
    assign result_rd_o     = result_valid_o ? head.rd     : '0;
    assign result_we_o     = result_valid_o ? head.we     : 1'b0;
    assign busy_o          = (state_q == MUL) || (count_q != '0);

endmodule

// File: tb/tb_cvxif_copro_exec_stage.sv
// Directed bench for cvxif_copro_exec_stage.
// Results are predicted at op acceptance and compared at pop.
module tb_cvxif_copro_exec_stage;

    typedef struct packed {
        logic [0:0]  hartid;
        logic [2:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } res_t;

    logic        clk;
    logic        rst_i;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [3:0]  opcode_i;
    logic [63:0] registers_i;
    logic [0:0]  hartid_i;
    logic [2:0]  id_i;
    logic [4:0]  rd_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [0:0]  result_hartid_o;
    logic [2:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic        busy_o;

    int   checks;
    int   errors;
    int   pops;
    logic acc;
    res_t q[$];

    cvxif_copro_exec_stage dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .op_valid_i      (op_valid_i),
        .op_ready_o      (op_ready_o),
        .opcode_i        (opcode_i),
        .registers_i     (registers_i),
        .hartid_i        (hartid_i),
        .id_i            (id_i),
        .rd_i            (rd_i),
        .result_valid_o  (result_valid_o),
        .result_ready_i  (result_ready_i),
        .result_hartid_o (result_hartid_o),
        .result_id_o     (result_id_o),
        .result_data_o   (result_data_o),
        .result_rd_o     (result_rd_o),
        .result_we_o     (result_we_o),
        .busy_o          (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] rd,
                                   input logic [2:0] id, input logic [0:0] h);
        res_t r;
        r.hartid = h;
        r.id     = id;
        r.rd     = rd;
        case (op)
            4'd1:    r.data = a + b;
            4'd2:    r.data = a - b;
            4'd3:    r.data = a * b;
            4'd4:    r.data = a + b;
            default: r.data = 32'd0;
        endcase
        r.we = (op >= 4'd1) && (op <= 4'd4) && (rd != 5'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard at negedge, return 1 time unit after posedge
    task automatic tick();
        res_t e;
        @(negedge clk);
        acc = 1'b0;
        if (rst_i) begin
            q.delete();
        end else begin
            if (result_valid_o && result_ready_i) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_pop", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    pops++;
                    chk("sb_data", result_data_o, e.data);
                    chk("sb_tags",
                        {20'd0, result_hartid_o, result_id_o, result_rd_o, result_we_o},
                        {20'd0, e.hartid, e.id, e.rd, e.we});
                end
            end
            if (op_valid_i && op_ready_o) begin
                acc = 1'b1;
                q.push_back(model(opcode_i, registers_i[31:0], registers_i[63:32],
                                  rd_i, id_i, hartid_i));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [2:0] id);
        opcode_i    = op;
        registers_i = {b, a};
        rd_i        = rd;
        id_i        = id;
        hartid_i    = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [2:0] id);
        set_op(op, a, b, rd, id);
        op_valid_i = 1'b1;
        acc        = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            tick();
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        op_valid_i = 1'b0;
    endtask

    task automatic drain();
        result_ready_i = 1'b1;
        for (int i = 0; i < 20 && (q.size() != 0); i++) begin
            tick();
        end
        chk("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        pops           = 0;
        acc            = 1'b0;
        rst_i          = 1'b1;
        op_valid_i     = 1'b0;
        result_ready_i = 1'b0;
        set_op(4'd0, 32'd0, 32'd0, 5'd0, 3'd0);
        tick();
        tick();
        rst_i = 1'b0;

        chk("rst_valid", result_valid_o, 32'd0);
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_data", result_data_o, 32'd0);
        chk("rst_ready", op_ready_o, 32'd1);

        result_ready_i = 1'b1;
        send(4'd1, 32'd5, 32'd7, 5'd3, 3'd2);
        chk("add_valid", result_valid_o, 32'd1);
        chk("add_data", result_data_o, 32'd12);
        chk("add_we", result_we_o, 32'd1);
        chk("add_rd", result_rd_o, 32'd3);
        chk("add_id", result_id_o, 32'd2);
        drain();

        send(4'd3, 32'hFFFF_FFFF, 32'd2, 5'd4, 3'd1);
        for (int i = 0; i < 3; i++) begin
            chk("mul_ready_low", op_ready_o, 32'd0);
            chk("mul_no_valid", result_valid_o, 32'd0);
            chk("mul_busy", busy_o, 32'd1);
            tick();
        end
        chk("mul_valid", result_valid_o, 32'd1);
        chk("mul_data", result_data_o, 32'hFFFF_FFFE);
        drain();

        send(4'd2, 32'd3, 32'd5, 5'd7, 3'd6);
        chk("sub_data", result_data_o, 32'hFFFF_FFFE);
        send(4'd4, 32'h8000_0000, 32'h8000_0001, 5'd8, 3'd7);
        drain();

        result_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(4'd1, 32'(i), 32'd100, 5'd1, 3'(i));
        end
        chk("full_ready_low", op_ready_o, 32'd0);
        chk("full_busy", busy_o, 32'd1);
        pops = 0;
        drain();
        chk("inorder_pops", pops, 32'd4);
        chk("drained_valid", result_valid_o, 32'd0);

        send(4'd9, 32'd1, 32'd2, 5'd5, 3'd3);
        chk("op9_data", result_data_o, 32'd0);
        chk("op9_we", result_we_o, 32'd0);
        send(4'd1, 32'd1, 32'd2, 5'd0, 3'd4);
        chk("rd0_we", result_we_o, 32'd0);
        chk("rd0_data", result_data_o, 32'd3);
        drain();

        result_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(4'd2, 32'd50, 32'(i), 5'd9, 3'(4 + i));
        end
        set_op(4'd1, 32'd20, 32'd22, 5'd10, 3'd0);
        op_valid_i     = 1'b1;
        result_ready_i = 1'b1;
        tick();
        chk("full_pop_no_accept", acc, 32'd0);
        tick();
        chk("accept_after_pop", acc, 32'd1);
        op_valid_i = 1'b0;
        drain();

        result_ready_i = 1'b0;
        send(4'd1, 32'd1, 32'd1, 5'd2, 3'd1);
        send(4'd1, 32'd2, 32'd2, 5'd2, 3'd2);
        send(4'd3, 32'd6, 32'd7, 5'd2, 3'd3);
        tick();
        chk("pre_rst_busy", busy_o, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("post_rst_valid", result_valid_o, 32'd0);
        chk("post_rst_busy", busy_o, 32'd0);
        chk("post_rst_ready", op_ready_o, 32'd1);
        result_ready_i = 1'b1;
        send(4'd1, 32'd40, 32'd2, 5'd11, 3'd5);
        chk("post_rst_add_valid", result_valid_o, 32'd1);
        chk("post_rst_add_data", result_data_o, 32'd42);
        drain();
        tick();
        chk("final_idle", busy_o, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
